// File: rtl/key_pkg.sv
// key_pkg: shared state encoding and sizing helpers for the multi-key filter.
package key_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'b0001,
      ST_FILT_DN = 4'b0010,
      ST_DOWN    = 4'b0100,
      ST_FILT_UP = 4'b1000
   } key_fsm_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Counter width that holds 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_filter_ch.sv
// key_filter_ch: one key channel -- synchroniser, debounce FSM, hold timer,
// registered event pulses and debounced level.
module key_filter_ch
   import key_pkg::*;
#(
   parameter int DEB_CNT   = 1_000_000,
   parameter int LONG_CNT  = 50_000_000,
   parameter int REP_CNT   = 10_000_000,
   parameter int REPEAT_EN = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key,
   output logic o_press,
   output logic o_release,
   output logic o_long,
   output logic o_repeat,
   output logic o_key_state
);

   localparam int DW = cnt_w(DEB_CNT);
   localparam int HW = cnt_w(max2(LONG_CNT, REP_CNT));
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);
   localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CNT - 1);
   localparam logic [HW-1:0] REP_LAST  = HW'(REP_CNT - 1);
   localparam logic [HW-1:0] HOLD_MAX  = '1;

   logic          r_s1, r_s2;
   key_fsm_e      r_state, w_state;
   logic [DW-1:0] r_deb, w_deb;
   logic [HW-1:0] r_hold, w_hold;
   logic          r_long_done, w_long_done;
   logic          r_press, w_press, r_release, w_release;
   logic          r_long, w_long, r_repeat, w_repeat;
   logic          r_key_state, w_key_state;

   // Pins idle high, so the synchroniser resets to 1 and no event leaves reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1 <= 1'b1;
         r_s2 <= 1'b1;
      end else begin
         r_s1 <= i_key;
         r_s2 <= r_s1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_deb       <= '0;
         r_hold      <= '0;
         r_long_done <= 1'b0;
         r_press     <= 1'b0;
         r_release   <= 1'b0;
         r_long      <= 1'b0;
         r_repeat    <= 1'b0;
         r_key_state <= 1'b1;
      end else begin
         r_state     <= w_state;
         r_deb       <= w_deb;
         r_hold      <= w_hold;
         r_long_done <= w_long_done;
         r_press     <= w_press;
         r_release   <= w_release;
         r_long      <= w_long;
         r_repeat    <= w_repeat;
         r_key_state <= w_key_state;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_deb       = r_deb;
      w_hold      = r_hold;
      w_long_done = r_long_done;
      w_press     = 1'b0;
      w_release   = 1'b0;
      w_long      = 1'b0;
      w_repeat    = 1'b0;
      w_key_state = r_key_state;
      case (r_state)
         ST_IDLE:
            if (!r_s2) begin
               w_state = ST_FILT_DN;
               w_deb   = '0;
            end
         ST_FILT_DN:
            if (r_s2)
               w_state = ST_IDLE;
            else if (r_deb == DEB_LAST) begin
               w_state     = ST_DOWN;
               w_press     = 1'b1;
               w_key_state = 1'b0;
               w_hold      = '0;
               w_long_done = 1'b0;
            end else
               w_deb = r_deb + 1'b1;
         // Hold only advances here, so a release bounce freezes it.
         ST_DOWN:
            if (r_s2) begin
               w_state = ST_FILT_UP;
               w_deb   = '0;
            end else if (!r_long_done && r_hold == LONG_LAST) begin
               w_long      = 1'b1;
               w_long_done = 1'b1;
               w_hold      = '0;
            end else if (r_long_done && (REPEAT_EN != 0) && r_hold == REP_LAST) begin
               w_repeat = 1'b1;
               w_hold   = '0;
            end else if (r_hold != HOLD_MAX)
               w_hold = r_hold + 1'b1;
         ST_FILT_UP:
            if (!r_s2)
               w_state = ST_DOWN;
            else if (r_deb == DEB_LAST) begin
               w_state     = ST_IDLE;
               w_release   = 1'b1;
               w_key_state = 1'b1;
            end else
               w_deb = r_deb + 1'b1;
         default:
            w_state = ST_IDLE;
      endcase
   end

   assign o_press     = r_press;
   assign o_release   = r_release;
   assign o_long      = r_long;
   assign o_repeat    = r_repeat;
   assign o_key_state = r_key_state;

endmodule

// File: rtl/key_filter_multi.sv
// key_filter_multi: NUM_KEYS independent debounced key channels with
// press/release/long-press/auto-repeat event pulses.
module key_filter_multi
   import key_pkg::*;
#(
   parameter int NUM_KEYS  = 4,
   parameter int DEB_CNT   = 1_000_000,
   parameter int LONG_CNT  = 50_000_000,
   parameter int REP_CNT   = 10_000_000,
   parameter int REPEAT_EN = 1
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NUM_KEYS-1:0] press_flag,
   output logic [NUM_KEYS-1:0] release_flag,
   output logic [NUM_KEYS-1:0] long_flag,
   output logic [NUM_KEYS-1:0] repeat_flag,
   output logic [NUM_KEYS-1:0] key_state
);

   genvar i;
   generate
      for (i = 0; i < NUM_KEYS; i++) begin : g_ch
         key_filter_ch #(
            .DEB_CNT  (DEB_CNT),
            .LONG_CNT (LONG_CNT),
            .REP_CNT  (REP_CNT),
            .REPEAT_EN(REPEAT_EN)
         ) u_ch (
            .i_clk      (Clk),
            .i_rst_n    (Rst_n),
            .i_key      (key_in[i]),
            .o_press    (press_flag[i]),
            .o_release  (release_flag[i]),
            .o_long     (long_flag[i]),
            .o_repeat   (repeat_flag[i]),
            .o_key_state(key_state[i])
         );
      end
   endgenerate

endmodule

// File: tb/tb_key_filter_multi.sv
// tb_key_filter_multi: two instances (auto-repeat on/off) checked against a
// run-length reference model, a phase table and directed timing sequences.
module tb_key_filter_multi;

   localparam int DEB  = 4;
   localparam int LONG = 20;
   localparam int REP  = 8;

   logic       clk, rst_n;
   logic [3:0] key_in;
   logic [3:0] pf0, rf0, lf0, qf0, ks0;
   logic [3:0] pf1, rf1, lf1, qf1, ks1;
   logic [19:0] act [2];

   int checks = 0;
   int failures = 0;

   key_filter_multi #(.NUM_KEYS(4), .DEB_CNT(DEB), .LONG_CNT(LONG), .REP_CNT(REP), .REPEAT_EN(1)) dut_r (
      .Clk(clk), .Rst_n(rst_n), .key_in(key_in),
      .press_flag(pf0), .release_flag(rf0), .long_flag(lf0), .repeat_flag(qf0), .key_state(ks0)
   );

   key_filter_multi #(.NUM_KEYS(4), .DEB_CNT(DEB), .LONG_CNT(LONG), .REP_CNT(REP), .REPEAT_EN(0)) dut_n (
      .Clk(clk), .Rst_n(rst_n), .key_in(key_in),
      .press_flag(pf1), .release_flag(rf1), .long_flag(lf1), .repeat_flag(qf1), .key_state(ks1)
   );

   assign act[0] = {pf0, rf0, lf0, qf0, ks0};
   assign act[1] = {pf1, rf1, lf1, qf1, ks1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Reference model: two-sample pin delay, then run lengths of the delayed
   // level decide acceptance; "t" counts uninterrupted held edges since press.
   bit          m_s1 [2][4];
   bit          m_s2 [2][4];
   bit          m_pr [2][4];
   int          m_run[2][4];
   int          m_t  [2][4];
   logic [19:0] m_exp[2];
   logic [3:0]  mp, mr, ml, mq, ms;

   always @(posedge clk or negedge rst_n) begin
      for (int m = 0; m < 2; m++) begin
         mp = '0; mr = '0; ml = '0; mq = '0; ms = '0;
         for (int c = 0; c < 4; c++) begin
            if (!rst_n) begin
               m_s1[m][c] = 1; m_s2[m][c] = 1; m_pr[m][c] = 0;
               m_run[m][c] = 0; m_t[m][c] = 0;
            end else begin
               if (!m_pr[m][c]) begin
                  m_run[m][c] = m_s2[m][c] ? 0 : m_run[m][c] + 1;
                  if (m_run[m][c] == DEB + 1) begin
                     m_pr[m][c] = 1; m_run[m][c] = 0; m_t[m][c] = 0; mp[c] = 1;
                  end
               end else if (m_s2[m][c]) begin
                  m_run[m][c]++;
                  if (m_run[m][c] == DEB + 1) begin
                     m_pr[m][c] = 0; m_run[m][c] = 0; mr[c] = 1;
                  end
               end else begin
                  if (m_run[m][c] == 0) begin
                     m_t[m][c]++;
                     if (m_t[m][c] == LONG) ml[c] = 1;
                     else if (m == 0 && m_t[m][c] > LONG && (m_t[m][c] - LONG) % REP == 0) mq[c] = 1;
                  end
                  m_run[m][c] = 0;
               end
               m_s2[m][c] = m_s1[m][c];
               m_s1[m][c] = key_in[c];
            end
            ms[c] = !m_pr[m][c];
         end
         m_exp[m] = {mp, mr, ml, mq, ms};
      end
   end

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
      end
   endtask

   task automatic tick(input logic [3:0] k);
      key_in = k;
      @(posedge clk);
      @(negedge clk);
      for (int m = 0; m < 2; m++)
         chk($sformatf("model inst%0d t=%0t", m, $time), {12'h0, act[m]}, {12'h0, m_exp[m]});
   endtask

   task automatic release_all(input int n);
      for (int i = 0; i < n; i++) tick(4'b1111);
   endtask

   typedef struct {
      logic [3:0] key;
      int         n;
      logic [3:0] st;
      logic [3:0] pr;
      logic [3:0] rl;
   } vec_t;

   vec_t tbl[9];
   logic [3:0] acc_p, acc_r;
   int p0, p2, l2, rl2, nr, nl_n, nq_n, other, glitch, sim_at, partial;
   int rp[4];

   initial begin
      tbl[0] = '{4'b1111, 8, 4'b1111, 4'b0000, 4'b0000};
      tbl[1] = '{4'b1010, 8, 4'b1010, 4'b0101, 4'b0000};
      tbl[2] = '{4'b1111, 2, 4'b1010, 4'b0000, 4'b0000};
      tbl[3] = '{4'b1010, 6, 4'b1010, 4'b0000, 4'b0000};
      tbl[4] = '{4'b1111, 8, 4'b1111, 4'b0000, 4'b0101};
      tbl[5] = '{4'b1101, 3, 4'b1111, 4'b0000, 4'b0000};
      tbl[6] = '{4'b1111, 6, 4'b1111, 4'b0000, 4'b0000};
      tbl[7] = '{4'b0000, 8, 4'b0000, 4'b1111, 4'b0000};
      tbl[8] = '{4'b1111, 8, 4'b1111, 4'b0000, 4'b1111};

      rst_n  = 1'b0;
      key_in = 4'b1111;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset inst0", {12'h0, act[0]}, 32'h0000_000F);
      chk("reset inst1", {12'h0, act[1]}, 32'h0000_000F);
      rst_n = 1'b1;

      for (int v = 0; v < 9; v++) begin
         acc_p = '0; acc_r = '0;
         for (int i = 0; i < tbl[v].n; i++) begin
            tick(tbl[v].key);
            acc_p |= pf0;
            acc_r |= rf0;
         end
         chk($sformatf("tbl%0d key_state", v), ks0, tbl[v].st);
         chk($sformatf("tbl%0d press", v), acc_p, tbl[v].pr);
         chk($sformatf("tbl%0d release", v), acc_r, tbl[v].rl);
      end

      // Clean press on 0, glitch on 1, long + repeat on 2, channel 3 idle.
      p0 = -1; p2 = -1; l2 = -1; nr = 0; nl_n = 0; nq_n = 0; other = 0; glitch = 0;
      for (int i = 0; i < 60; i++) begin
         tick({1'b1, 1'b0, (i < 2) ? 1'b0 : 1'b1, 1'b0});
         if (pf0[0] && p0 < 0) p0 = i;
         if (pf0[2]) p2 = i;
         if (lf0[2]) l2 = i;
         if (qf0[2]) begin
            if (nr < 4) rp[nr] = i;
            nr++;
         end
         if (lf1[2]) nl_n++;
         if (qf1 != 0) nq_n++;
         if ({pf0[1], rf0[1], lf0[1], qf0[1], !ks0[1]} != 0) glitch++;
         if ({pf0[3], rf0[3], lf0[3], qf0[3], !ks0[3]} != 0) other++;
      end
      chk("press0 latency", p0, DEB + 2);
      chk("press2 latency", p2, DEB + 2);
      chk("long2 latency", l2, DEB + 2 + LONG);
      chk("repeat2 count", nr, 4);
      chk("repeat2 first", rp[0], DEB + 2 + LONG + REP);
      chk("repeat2 second", rp[1], DEB + 2 + LONG + 2 * REP);
      chk("repeat2 third", rp[2], DEB + 2 + LONG + 3 * REP);
      chk("glitch ch1 events", glitch, 0);
      chk("idle ch3 events", other, 0);
      chk("norep long count", nl_n, 1);
      chk("norep repeat count", nq_n, 0);
      chk("held key_state", ks0, 4'b1010);

      rl2 = -1;
      for (int i = 0; i < 12; i++) begin
         tick(4'b1111);
         if (rf0[2]) rl2 = i;
      end
      chk("release2 latency", rl2, DEB + 2);

      // Release bounce of two cycles in DOWN: hold pauses, long fires once.
      l2 = -1; nr = 0; glitch = 0;
      for (int i = 0; i < 45; i++) begin
         tick({3'b111, (i == 10 || i == 11) ? 1'b1 : 1'b0});
         if (lf0[0]) begin
            l2 = i;
            nr++;
         end
         if (rf0[0]) glitch++;
      end
      chk("bounce no release", glitch, 0);
      chk("bounce long count", nr, 1);
      chk("bounce long latency", l2, DEB + 2 + LONG + 3);
      release_all(12);

      sim_at = -1; partial = 0;
      for (int i = 0; i < 8; i++) begin
         tick(4'b0000);
         if (pf0 == 4'b1111) sim_at = i;
         else if (pf0 != 0) partial++;
      end
      chk("simultaneous press", sim_at, DEB + 2);
      chk("simultaneous partial", partial, 0);
      release_all(12);

      // Asynchronous reset while channel 0 is held down.
      for (int i = 0; i < 10; i++) tick(4'b1110);
      #2 rst_n = 1'b0;
      #1 chk("reset async", {12'h0, act[0]}, 32'h0000_000F);
      @(negedge clk);
      chk("reset no release", rf0, 4'b0000);
      rst_n = 1'b1;
      p0 = -1;
      for (int i = 0; i < 10; i++) begin
         tick(4'b1110);
         if (pf0[0]) p0 = i;
      end
      chk("press after reset", p0, DEB + 2);
      release_all(12);

      begin
         int rem[4];
         logic [3:0] lvl;
         lvl = 4'b1111;
         for (int c = 0; c < 4; c++) rem[c] = 0;
         for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < 4; c++) begin
               if (rem[c] == 0) begin
                  lvl[c] = ~lvl[c];
                  rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(1, 60));
               end
               rem[c]--;
            end
            tick(lvl);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
